// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 2-bit-opcode datapath.
// Drives datapath strobes, runs the memory req/ack handshake with timeout, counts retirements.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Clear_n,
  input  logic             Start,
  input  logic [1:0]       Opcode,
  input  logic             Zero,
  input  logic             MemAck,
  input  logic             Stall,
  output logic             MemReq,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             ALUOp,
  output logic             MemtoReg,
  output logic             Busy,
  output logic             Fault,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_LD = 2'b01;
  localparam logic [1:0] OP_ST = 2'b10;
  localparam logic [1:0] OP_BR = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             timeout;

  assign timeout = (timer_q == 8'(MEM_TIMEOUT));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    retire   = 1'b0;
    MemReq   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 1'b0;
    MemtoReg = 1'b0;
    Fault    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_FETCH;
      end
      S_FETCH: begin
        MemReq  = 1'b1;
        MemRead = 1'b1;
        if (MemAck) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (!Stall) begin
          op_d    = Opcode;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!Stall) begin
          unique case (op_q)
            OP_R: begin
              ALUOp   = 1'b1;
              state_d = S_WB;
            end
            OP_LD, OP_ST: begin
              ALUSrc  = 1'b1;
              ALUOp   = 1'b1;
              state_d = S_MEM;
            end
            OP_BR: begin
              PCWrite = Zero;
              PCSrc   = Zero;
              retire  = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_MEM: begin
        MemReq   = 1'b1;
        MemRead  = (op_q == OP_LD);
        MemWrite = (op_q == OP_ST);
        if (MemAck) begin
          if (op_q == OP_LD) state_d = S_WB;
          else               retire  = 1'b1;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        if (!Stall) begin
          RegWrite = 1'b1;
          RegDst   = (op_q == OP_R);
          MemtoReg = (op_q == OP_LD);
          retire   = 1'b1;
        end
      end
      S_FAULT: begin
        Fault = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Every instruction end chains straight into the next fetch while Start is held
    if (retire) state_d = Start ? S_FETCH : S_IDLE;
  end

  assign Busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign InstrCount = cnt_q;
  assign timer_d    = (MemReq && !MemAck) ? timer_q + 8'd1 : 8'd0;
  assign cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, retire};

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      timer_q <= 8'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
